// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decoder control-bundle layout and bubble constant
//
// Purpose: single definition of the 14-bit control bundle produced by the
// decoder and carried down the pipeline, so decoder and ID/EX agree on
// field positions.
// Contents: ctrl_t (MSB first: aluOp[2:0], regDst, aluSrcA, aluSrcB,
// aluSrcBb, memToReg, regWrite, memRead, memWrite, branch[1:0], jal),
// CTRL_W, CTRL_MEM_READ_BIT, CTRL_NOP, ctrlGate(), ctrlMemRead().
package cpu_pkg;

  localparam int CTRL_W            = 14;
  localparam int CTRL_MEM_READ_BIT = 4;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       regDst;
    logic       aluSrcA;
    logic       aluSrcB;
    logic       aluSrcBb;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] branch;
    logic       jal;
  } ctrl_t;

  // All-zero bundle: no register write, no memory access, no branch.
  localparam ctrl_t CTRL_NOP = '0;

  // An invalid slot must never carry live control bits.
  function automatic ctrl_t ctrlGate(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : CTRL_NOP;
  endfunction

  function automatic logic ctrlMemRead(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ_BIT];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decoded-operand bus between ID and EX
//
// Purpose: groups the ID-side operand inputs and the registered EX-side
// copies of the ID/EX pipeline register.
// Modports: master (ID/bench side: drives id_*, observes ex_*),
//           slave  (id_ex_stage: reads id_*, drives ex_*).
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic [31:0] id_imm_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [4:0]  id_rd_i;
  logic [4:0]  id_shamt_i;
  logic        id_uses_rt_i;
  ctrl_t       id_ctrl_i;

  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [31:0] ex_rs_data_o;
  logic [31:0] ex_rt_data_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs_o;
  logic [4:0]  ex_rt_o;
  logic [4:0]  ex_rd_o;
  logic [4:0]  ex_shamt_o;
  ctrl_t       ex_ctrl_o;

  modport master (
    output id_valid_i, id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i, id_shamt_i, id_uses_rt_i, id_ctrl_i,
    input  ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o, ex_ctrl_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i, id_shamt_i, id_uses_rt_i, id_ctrl_i,
    output ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
           ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o, ex_ctrl_o
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the instruction in ID reads the destination of a load
// currently in EX, whose data is not available until after MEM.
// Ports: exValid, exMemRead, exRt (load in EX); idValid, idRs, idRt,
//        idUsesRt (consumer in ID); loadUse (raw hazard, not yet gated by
//        hold/flush).
module hazard_detect (
  input  logic       exValid,
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  output logic       loadUse
);

  // $zero is never a real dependency, so a load targeting it never stalls.
  assign loadUse = exValid & exMemRead & (exRt != 5'd0) & idValid &
                   ((exRt == idRs) | (idUsesRt & (exRt == idRt)));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush, hold and load-use bubble
//
// Purpose: one-cycle register from decode to execute. Each edge resolves
// reset > hold > flush (incl. pending) > load-use bubble > normal load.
// A flush that arrives while held is remembered and applied on the first
// free edge.
// Ports: clk, rst_n (sync, active-low), hold_i (freeze), flush_i (discard
//        entering instruction), stall_o (load-use, comb), bus (slave side
//        of id_ex_stage_if carrying id_* and ex_*).
// Build option: ID_EX_HAZARD_DETECT_EN enables load-use stall/bubble;
//               undefined ties stall_o to 0.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_i,
  input  logic          flush_i,
  output logic          stall_o,
  id_ex_stage_if.slave  bus
);

  logic        exValid;
  logic [31:0] exPc;
  logic [31:0] exRsData;
  logic [31:0] exRtData;
  logic [31:0] exImm;
  logic [4:0]  exRs;
  logic [4:0]  exRt;
  logic [4:0]  exRd;
  logic [4:0]  exShamt;
  ctrl_t       exCtrl;

  logic flushPending;
  logic flushNow;
  logic loadUse;
  logic bubble;

  assign flushNow = flush_i | flushPending;

  hazard_detect uHazard (
    .exValid   (exValid),
    .exMemRead (ctrlMemRead(exCtrl)),
    .exRt      (exRt),
    .idValid   (bus.id_valid_i),
    .idRs      (bus.id_rs_i),
    .idRt      (bus.id_rt_i),
    .idUsesRt  (bus.id_uses_rt_i),
    .loadUse   (loadUse)
  );

`ifdef ID_EX_HAZARD_DETECT_EN
  // Hold or a flush already resolves the cycle; stalling upstream would
  // only lose the redirect.
  assign stall_o = loadUse & ~hold_i & ~flushNow;
`else
  logic unusedLoadUse;
  assign unusedLoadUse = loadUse;
  assign stall_o       = 1'b0;
`endif

  assign bubble = flushNow | stall_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exValid      <= 1'b0;
      exPc         <= '0;
      exRsData     <= '0;
      exRtData     <= '0;
      exImm        <= '0;
      exRs         <= '0;
      exRt         <= '0;
      exRd         <= '0;
      exShamt      <= '0;
      exCtrl       <= CTRL_NOP;
      flushPending <= 1'b0;
    end else if (hold_i) begin
      if (flush_i) flushPending <= 1'b1;
    end else begin
      flushPending <= 1'b0;
      if (bubble) begin
        exValid  <= 1'b0;
        exPc     <= '0;
        exRsData <= '0;
        exRtData <= '0;
        exImm    <= '0;
        exRs     <= '0;
        exRt     <= '0;
        exRd     <= '0;
        exShamt  <= '0;
        exCtrl   <= CTRL_NOP;
      end else begin
        exValid  <= bus.id_valid_i;
        exPc     <= bus.id_pc_i;
        exRsData <= bus.id_rs_data_i;
        exRtData <= bus.id_rt_data_i;
        exImm    <= bus.id_imm_i;
        exRs     <= bus.id_rs_i;
        exRt     <= bus.id_rt_i;
        exRd     <= bus.id_rd_i;
        exShamt  <= bus.id_shamt_i;
        exCtrl   <= ctrlGate(bus.id_valid_i, bus.id_ctrl_i);
      end
    end
  end

  assign bus.ex_valid_o   = exValid;
  assign bus.ex_pc_o      = exPc;
  assign bus.ex_rs_data_o = exRsData;
  assign bus.ex_rt_data_o = exRtData;
  assign bus.ex_imm_o     = exImm;
  assign bus.ex_rs_o      = exRs;
  assign bus.ex_rt_o      = exRt;
  assign bus.ex_rd_o      = exRd;
  assign bus.ex_shamt_o   = exShamt;
  assign bus.ex_ctrl_o    = exCtrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import cpu_pkg::*;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam logic HAZARD_EN = 1'b1;
`else
  localparam logic HAZARD_EN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    ctrl_t       ctrl;
  } exState_t;

  logic clk = 1'b0;
  logic rst_n;
  logic hold_i;
  logic flush_i;
  logic stall_o;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .bus     (bus)
  );

  int       vectors     = 0;
  int       miscompares = 0;
  exState_t model;
  logic     modelPending;
  exState_t expQ[$];
  ctrl_t    lwCtrl;
  ctrl_t    addCtrl;

  function automatic exState_t dutState();
    return {bus.ex_valid_o, bus.ex_pc_o, bus.ex_rs_data_o, bus.ex_rt_data_o,
            bus.ex_imm_o, bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o,
            bus.ex_shamt_o, bus.ex_ctrl_o};
  endfunction

  function automatic exState_t idState();
    exState_t s;
    s = {bus.id_valid_i, bus.id_pc_i, bus.id_rs_data_i, bus.id_rt_data_i,
         bus.id_imm_i, bus.id_rs_i, bus.id_rt_i, bus.id_rd_i,
         bus.id_shamt_i, bus.id_ctrl_i};
    if (!s.valid) s.ctrl = '0;
    return s;
  endfunction

  function automatic logic expectStall();
    logic hit;
    hit = model.valid & model.ctrl.memRead & (model.rt != 5'd0) &
          bus.id_valid_i &
          ((model.rt == bus.id_rs_i) |
           (bus.id_uses_rt_i & (model.rt == bus.id_rt_i)));
    return HAZARD_EN & hit & ~hold_i & ~flush_i & ~modelPending;
  endfunction

  task automatic setId(input logic valid, input logic [31:0] pc,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic usesRt,
                       input ctrl_t ctrl);
    bus.id_valid_i   = valid;
    bus.id_pc_i      = pc;
    bus.id_rs_data_i = $urandom();
    bus.id_rt_data_i = $urandom();
    bus.id_imm_i     = $urandom();
    bus.id_rs_i      = rs;
    bus.id_rt_i      = rt;
    bus.id_rd_i      = rd;
    bus.id_shamt_i   = 5'($urandom_range(0, 31));
    bus.id_uses_rt_i = usesRt;
    bus.id_ctrl_i    = ctrl;
  endtask

  // Called at posedge+1 with inputs already driven; checks stall_o before
  // the edge, predicts the register contents and scores them after it.
  task automatic applyCycle(input string tag);
    exState_t nxt;
    exState_t got;
    exState_t exp;
    logic     st;
    logic     pend;
    #1;
    st = expectStall();
    if (rst_n) begin
      vectors++;
      if (stall_o !== st) begin
        miscompares++;
        $display("FAIL %s.stall: got %b expected %b", tag, stall_o, st);
      end
    end
    pend = modelPending;
    if (!rst_n) begin
      nxt  = '0;
      pend = 1'b0;
    end else if (hold_i) begin
      nxt = model;
      if (flush_i) pend = 1'b1;
    end else begin
      if (flush_i | modelPending | st) nxt = '0;
      else nxt = idState();
      pend = 1'b0;
    end
    expQ.push_back(nxt);
    @(posedge clk);
    model        = nxt;
    modelPending = pend;
    #1;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL %s.queue: got empty expected entry", tag);
    end else begin
      exp = expQ.pop_front();
      got = dutState();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s.ex: got %h expected %h", tag, got, exp);
      end
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    hold_i  = 1'b1;
    flush_i = 1'b0;
    setId(1'b1, 32'h1234, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    @(posedge clk);
    @(posedge clk);
    #1;
    model        = '0;
    modelPending = 1'b0;
    vectors++;
    if (dutState() !== exState_t'('0)) begin
      miscompares++;
      $display("FAIL reset.ex: got %h expected 0", dutState());
    end
    checkBit("reset.stall", stall_o, 1'b0);
    rst_n  = 1'b1;
    hold_i = 1'b0;
  endtask

  task automatic test_basic();
    ctrl_t c;
    c          = '0;
    c.regWrite = 1'b1;
    setId(1'b1, 32'h0000_0040, 5'd4, 5'd5, 5'd6, 1'b1, c);
    applyCycle("basic");
    vectors++;
    if (bus.ex_pc_o !== 32'h40) begin
      miscompares++;
      $display("FAIL basic.pc: got %h expected 00000040", bus.ex_pc_o);
    end
    checkBit("basic.valid", bus.ex_valid_o, 1'b1);
  endtask

  task automatic test_load_use();
    setId(1'b1, 32'h100, 5'd2, 5'd8, 5'd8, 1'b0, lwCtrl);
    applyCycle("lu.lw");
    setId(1'b1, 32'h104, 5'd8, 5'd9, 5'd10, 1'b1, addCtrl);
    #1;
    checkBit("lu.stall", stall_o, HAZARD_EN);
    applyCycle("lu.add");
    checkBit("lu.valid", bus.ex_valid_o, ~HAZARD_EN);
    vectors++;
    if (bus.ex_ctrl_o !== (HAZARD_EN ? CTRL_NOP : addCtrl)) begin
      miscompares++;
      $display("FAIL lu.ctrl: got %h expected %h", bus.ex_ctrl_o,
               HAZARD_EN ? CTRL_NOP : addCtrl);
    end
    applyCycle("lu.readd");
    checkBit("lu.readd.valid", bus.ex_valid_o, 1'b1);
  endtask

  task automatic test_zero_reg();
    setId(1'b1, 32'h140, 5'd3, 5'd0, 5'd0, 1'b0, lwCtrl);
    applyCycle("zero.lw");
    setId(1'b1, 32'h144, 5'd0, 5'd0, 5'd11, 1'b1, addCtrl);
    #1;
    checkBit("zero.stall", stall_o, 1'b0);
    applyCycle("zero.add");
    checkBit("zero.valid", bus.ex_valid_o, 1'b1);
  endtask

  task automatic test_rt_use();
    setId(1'b1, 32'h180, 5'd1, 5'd9, 5'd9, 1'b0, lwCtrl);
    applyCycle("rt.lw");
    setId(1'b0, 32'h184, 5'd9, 5'd9, 5'd12, 1'b1, addCtrl);
    #1;
    checkBit("rt.invalid_id", stall_o, 1'b0);
    setId(1'b1, 32'h184, 5'd3, 5'd9, 5'd12, 1'b0, addCtrl);
    #1;
    checkBit("rt.no_use", stall_o, 1'b0);
    bus.id_uses_rt_i = 1'b1;
    #1;
    checkBit("rt.use", stall_o, HAZARD_EN);
    flush_i = 1'b1;
    #1;
    checkBit("rt.flush_masks", stall_o, 1'b0);
    flush_i = 1'b0;
    applyCycle("rt.add");
  endtask

  task automatic test_invalid();
    setId(1'b0, 32'h1c0, 5'd1, 5'd2, 5'd3, 1'b1, ctrl_t'('1));
    applyCycle("inv");
    checkBit("inv.valid", bus.ex_valid_o, 1'b0);
    vectors++;
    if (bus.ex_ctrl_o !== CTRL_NOP) begin
      miscompares++;
      $display("FAIL inv.ctrl: got %h expected 0", bus.ex_ctrl_o);
    end
  endtask

  task automatic test_hold_flush();
    setId(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    applyCycle("hf.load");
    setId(1'b1, 32'h204, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    hold_i  = 1'b1;
    flush_i = 1'b1;
    applyCycle("hf.hold_flush");
    vectors++;
    if (bus.ex_pc_o !== 32'h200) begin
      miscompares++;
      $display("FAIL hf.held_pc: got %h expected 00000200", bus.ex_pc_o);
    end
    flush_i = 1'b0;
    setId(1'b1, 32'h208, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    applyCycle("hf.hold");
    hold_i = 1'b0;
    setId(1'b1, 32'h20c, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    applyCycle("hf.pending");
    checkBit("hf.bubble", bus.ex_valid_o, 1'b0);
    setId(1'b1, 32'h210, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    applyCycle("hf.resume");
    vectors++;
    if (bus.ex_pc_o !== 32'h210) begin
      miscompares++;
      $display("FAIL hf.resume_pc: got %h expected 00000210", bus.ex_pc_o);
    end
    flush_i = 1'b1;
    applyCycle("hf.flush");
    flush_i = 1'b0;
  endtask

  task automatic test_reset_hold();
    setId(1'b1, 32'h2f0, 5'd1, 5'd7, 5'd7, 1'b0, lwCtrl);
    applyCycle("rh.lw");
    hold_i  = 1'b1;
    flush_i = 1'b1;
    applyCycle("rh.pend");
    flush_i = 1'b0;
    rst_n   = 1'b0;
    applyCycle("rh.reset");
    checkBit("rh.stall", stall_o, 1'b0);
    rst_n  = 1'b1;
    hold_i = 1'b0;
    setId(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 1'b1, addCtrl);
    applyCycle("rh.after");
    checkBit("rh.after_valid", bus.ex_valid_o, 1'b1);
  endtask

  task automatic test_back_to_back();
    ctrl_t c;
    for (int i = 0; i < 80; i++) begin
      c         = ctrl_t'($urandom_range(0, 16383));
      c.memRead = ($urandom_range(0, 1) == 1);
      setId(($urandom_range(0, 3) != 0), $urandom(),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1), c);
      hold_i  = ($urandom_range(0, 6) == 0);
      flush_i = ($urandom_range(0, 6) == 0);
      applyCycle("b2b");
    end
    hold_i  = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    lwCtrl          = '0;
    lwCtrl.memRead  = 1'b1;
    lwCtrl.regWrite = 1'b1;
    lwCtrl.memToReg = 1'b1;
    lwCtrl.aluSrcB  = 1'b1;
    addCtrl          = '0;
    addCtrl.aluOp    = 3'b010;
    addCtrl.regDst   = 1'b1;
    addCtrl.regWrite = 1'b1;
    model        = '0;
    modelPending = 1'b0;
    rst_n        = 1'b0;
    hold_i       = 1'b0;
    flush_i      = 1'b0;
    setId(1'b0, '0, '0, '0, '0, 1'b0, CTRL_NOP);
    #2;
    test_reset();
    test_basic();
    test_load_use();
    test_zero_reg();
    test_rt_use();
    test_invalid();
    test_hold_flush();
    test_reset_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
